// File: rtl/assist_pkg.sv
// Shared definitions for the pedal-assist PI controller.
// Holds the FSM state encoding and the default widths, gains and
// tilt thresholds used by assist_pi_controller and assist_pi_core.
package assist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSIST = 2'd1,
        COAST  = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int DEF_OUT_W       = 13;
    localparam int DEF_HR_W        = 8;
    localparam int DEF_ANG_W       = 10;
    localparam int DEF_KP          = 50;
    localparam int DEF_KI          = 2;
    localparam int DEF_KPITCH      = 50;
    localparam int DEF_TILT_MAX    = 45;
    localparam int DEF_TILT_CLR    = 30;
    localparam int DEF_CLR_SAMPLES = 16;
    localparam int DEF_INTEG_MAX   = 1024;
    localparam int DEF_RAMP_STEP   = 64;
    localparam int DEF_SAMPLE_DIV  = 50000;

endpackage

// File: rtl/assist_pi_core.sv
// PI arithmetic for the assist controller.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   update       - one-cycle strobe: advance the integrator this clock
//   clear        - zero the integrator and clamp history
//   heart_rate   - measured heart rate (unsigned bpm)
//   hr_setpoint  - heart-rate setpoint (unsigned bpm)
//   pitch        - signed pitch angle; only uphill (positive) pitch adds torque
//   target       - clamped torque target, 0 .. 2^OUT_W-1
// The target reflects the integrator value that this update will store, so
// the ramp logic in the top sees the freshly integrated demand on the tick.
module assist_pi_core
    import assist_pkg::*;
#(
    parameter int OUT_W     = DEF_OUT_W,
    parameter int HR_W      = DEF_HR_W,
    parameter int ANG_W     = DEF_ANG_W,
    parameter int KP        = DEF_KP,
    parameter int KI        = DEF_KI,
    parameter int KPITCH    = DEF_KPITCH,
    parameter int INTEG_MAX = DEF_INTEG_MAX
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    update,
    input  logic                    clear,
    input  logic [HR_W-1:0]         heart_rate,
    input  logic [HR_W-1:0]         hr_setpoint,
    input  logic signed [ANG_W-1:0] pitch,
    output logic [OUT_W-1:0]        target
);

    // Integrator width covers +/-INTEG_MAX and at least one error sample.
    localparam int IB = $clog2(INTEG_MAX + 1);
    localparam int IW = ((IB > HR_W + 1) ? IB : HR_W + 1) + 1;
    // 32-bit gains times narrow operands, summed three ways, fit easily in 48.
    localparam int TW = 48;

    localparam logic signed [IW:0]   IMAX     = (IW+1)'(INTEG_MAX);
    localparam logic signed [IW:0]   IMIN     = -IMAX;
    localparam logic signed [TW-1:0] KP_T     = TW'(KP);
    localparam logic signed [TW-1:0] KI_T     = TW'(KI);
    localparam logic signed [TW-1:0] KPITCH_T = TW'(KPITCH);
    localparam logic signed [TW-1:0] TMAX     = TW'((2 ** OUT_W) - 1);

    logic signed [HR_W:0]   err;
    logic signed [IW-1:0]   integ;
    logic signed [IW:0]     isum;
    logic signed [IW-1:0]   integ_sat;
    logic signed [IW-1:0]   integ_use;
    logic signed [TW-1:0]   pitch_pos;
    logic signed [TW-1:0]   raw;
    logic                   clamp_hi;
    logic                   clamp_lo;
    logic                   err_pos;
    logic                   err_neg;
    logic                   freeze;

    assign err     = $signed({1'b0, heart_rate}) - $signed({1'b0, hr_setpoint});
    assign err_neg = err[HR_W];
    assign err_pos = !err[HR_W] && (err != '0);

    // Anti-windup: hold the integrator while the last target sat on a rail
    // and the error would drive it further into that rail.
    assign freeze = (clamp_hi && err_pos) || (clamp_lo && err_neg);

    always_comb begin
        isum = {integ[IW-1], integ} + (IW+1)'(err);
        if (isum > IMAX) begin
            integ_sat = IMAX[IW-1:0];
        end else if (isum < IMIN) begin
            integ_sat = IMIN[IW-1:0];
        end else begin
            integ_sat = isum[IW-1:0];
        end
        integ_use = (update && !freeze) ? integ_sat : integ;
    end

    assign pitch_pos = pitch[ANG_W-1] ? '0 : TW'(pitch);
    assign raw = KP_T * TW'(err) + KI_T * TW'(integ_use) + KPITCH_T * pitch_pos;

    always_comb begin
        if (raw[TW-1]) begin
            target = '0;
        end else if (raw > TMAX) begin
            target = '1;
        end else begin
            target = raw[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ    <= '0;
            clamp_hi <= 1'b0;
            clamp_lo <= 1'b0;
        end else if (clear) begin
            integ    <= '0;
            clamp_hi <= 1'b0;
            clamp_lo <= 1'b0;
        end else if (update) begin
            integ    <= integ_use;
            clamp_hi <= (raw > TMAX);
            clamp_lo <= raw[TW-1];
        end
    end

endmodule

// File: rtl/assist_pi_controller.sv
// Pedal-assist torque controller: heart-rate PI loop with pitch feed-forward,
// rate-limited torque ramp, brake cut-off and latched tilt protection.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   roll, pitch  - signed resolved angles
//   heart_rate   - measured heart rate (bpm), hr_setpoint - target (bpm)
//   cadence      - rider is pedalling, brake - brake lever pulled
//   assist_req   - unsigned torque request
//   tilt_fault   - high while in FAULT
//   state        - FSM state (IDLE/ASSIST/COAST/FAULT)
//   sample_tick  - one-cycle strobe every SAMPLE_DIV clocks
module assist_pi_controller
    import assist_pkg::*;
#(
    parameter int OUT_W       = DEF_OUT_W,
    parameter int HR_W        = DEF_HR_W,
    parameter int ANG_W       = DEF_ANG_W,
    parameter int KP          = DEF_KP,
    parameter int KI          = DEF_KI,
    parameter int KPITCH      = DEF_KPITCH,
    parameter int TILT_MAX    = DEF_TILT_MAX,
    parameter int TILT_CLR    = DEF_TILT_CLR,
    parameter int CLR_SAMPLES = DEF_CLR_SAMPLES,
    parameter int INTEG_MAX   = DEF_INTEG_MAX,
    parameter int RAMP_STEP   = DEF_RAMP_STEP,
    parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ANG_W-1:0] roll,
    input  logic signed [ANG_W-1:0] pitch,
    input  logic [HR_W-1:0]         heart_rate,
    input  logic [HR_W-1:0]         hr_setpoint,
    input  logic                    cadence,
    input  logic                    brake,
    output logic [OUT_W-1:0]        assist_req,
    output logic                    tilt_fault,
    output logic [1:0]              state,
    output logic                    sample_tick
);

    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int RW = $clog2(CLR_SAMPLES + 1);

    localparam logic [DW-1:0]    DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [RW-1:0]    CLR_LAST = RW'(CLR_SAMPLES - 1);
    localparam logic [ANG_W-1:0] A_MAX    = ANG_W'(TILT_MAX);
    localparam logic [ANG_W-1:0] A_CLR    = ANG_W'(TILT_CLR);
    localparam logic [OUT_W-1:0] STEP     = OUT_W'(RAMP_STEP);

    // Magnitude as unsigned ANG_W bits: the most-negative code maps to
    // 2^(ANG_W-1), i.e. the largest possible magnitude.
    function automatic logic [ANG_W-1:0] mag(input logic [ANG_W-1:0] a);
        return a[ANG_W-1] ? (~a + ANG_W'(1)) : a;
    endfunction

    state_t             st, st_n;
    logic [DW-1:0]      div_cnt;
    logic [RW-1:0]      rec_cnt;
    logic               tilt;
    logic               clr_ok;
    logic [OUT_W-1:0]   target;
    logic [OUT_W-1:0]   req_ramp;
    logic [OUT_W-1:0]   req_coast;
    logic               pi_update;
    logic               pi_clear;

    assign state  = st;
    assign tilt   = (mag(roll) > A_MAX) || (mag(pitch) > A_MAX);
    assign clr_ok = (mag(roll) <= A_CLR) && (mag(pitch) <= A_CLR);

    // Sample divider and strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            sample_tick <= (div_cnt == DIV_LAST);
        end
    end

    always_comb begin
        st_n = st;
        unique case (st)
            IDLE:   if (cadence && !brake) st_n = ASSIST;
            ASSIST: if (brake || !cadence) st_n = COAST;
            COAST: begin
                if (cadence && !brake) begin
                    st_n = ASSIST;
                end else if (!cadence && (assist_req == '0)) begin
                    st_n = IDLE;
                end
            end
            FAULT:  if (sample_tick && clr_ok && (rec_cnt == CLR_LAST)) st_n = IDLE;
            default: st_n = IDLE;
        endcase
        if (tilt) begin
            st_n = FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            tilt_fault <= 1'b0;
        end else begin
            st         <= st_n;
            tilt_fault <= (st_n == FAULT);
        end
    end

    // Consecutive clean-sample count while latched in FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_cnt <= '0;
        end else if (st != FAULT) begin
            rec_cnt <= '0;
        end else if (sample_tick) begin
            if (!clr_ok || (rec_cnt == CLR_LAST)) begin
                rec_cnt <= '0;
            end else begin
                rec_cnt <= rec_cnt + RW'(1);
            end
        end
    end

    assign pi_update = sample_tick && (st == ASSIST);
    assign pi_clear  = (st_n == FAULT) || (st_n == IDLE);

    assist_pi_core #(
        .OUT_W     (OUT_W),
        .HR_W      (HR_W),
        .ANG_W     (ANG_W),
        .KP        (KP),
        .KI        (KI),
        .KPITCH    (KPITCH),
        .INTEG_MAX (INTEG_MAX)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .update      (pi_update),
        .clear       (pi_clear),
        .heart_rate  (heart_rate),
        .hr_setpoint (hr_setpoint),
        .pitch       (pitch),
        .target      (target)
    );

    // Rise is rate limited; fall goes straight to the target.
    always_comb begin
        if (target > assist_req) begin
            req_ramp = ((target - assist_req) > STEP) ? assist_req + STEP : target;
        end else begin
            req_ramp = target;
        end
        req_coast = (assist_req > STEP) ? assist_req - STEP : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assist_req <= '0;
        end else if (tilt || brake || (st == FAULT) || (st == IDLE)) begin
            assist_req <= '0;
        end else if (sample_tick) begin
            if (st == ASSIST) begin
                assist_req <= req_ramp;
            end else if (st == COAST) begin
                assist_req <= req_coast;
            end
        end
    end

endmodule

// File: tb/tb_assist_pi_controller.sv
// Directed self-checking bench for assist_pi_controller (SAMPLE_DIV = 4).
module tb_assist_pi_controller;

    localparam int DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [9:0] roll;
    logic signed [9:0] pitch;
    logic [7:0]        heart_rate;
    logic [7:0]        hr_setpoint;
    logic              cadence;
    logic              brake;
    logic [12:0]       assist_req;
    logic              tilt_fault;
    logic [1:0]        state;
    logic              sample_tick;

    int total = 0;
    int bad   = 0;
    int nt;

    assist_pi_controller #(
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .roll        (roll),
        .pitch       (pitch),
        .heart_rate  (heart_rate),
        .hr_setpoint (hr_setpoint),
        .cadence     (cadence),
        .brake       (brake),
        .assist_req  (assist_req),
        .tilt_fault  (tilt_fault),
        .state       (state),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait for n sample ticks; returns on the negedge after the clock that
    // consumed the last tick, so registered outputs reflect that sample.
    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            @(negedge clk);
            while (sample_tick !== 1'b1 && t < 4 * DIV) begin
                @(negedge clk);
                t++;
            end
            if (sample_tick !== 1'b1) begin
                total++;
                bad++;
                $error("FAIL tick_timeout: observed=%0d expected=1", sample_tick);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; roll = '0; pitch = '0;
        heart_rate = 8'd120; hr_setpoint = 8'd120;
        cadence = 1'b0; brake = 1'b0;
        #1;
        chk("rst_req",   32'(assist_req), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_tilt",  32'(tilt_fault), 0);
        chk("rst_tick",  32'(sample_tick), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Ramp-up: err=30 -> 64,128,192 per tick
        cadence = 1'b1; heart_rate = 8'd150;
        tick_wait(1); chk("ramp1", 32'(assist_req), 64);
        tick_wait(1); chk("ramp2", 32'(assist_req), 128);
        tick_wait(1); chk("ramp3", 32'(assist_req), 192);

        // Async reset between ticks
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(assist_req), 0);
        chk("arst_state", 32'(state), 0);
        chk("arst_tilt",  32'(tilt_fault), 0);
        chk("arst_tick",  32'(sample_tick), 0);
        chk("arst_integ", 32'(dut.u_core.integ), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("first_tick_early", 32'(sample_tick), 0);
        @(negedge clk);
        chk("first_tick", 32'(sample_tick), 1);
        @(negedge clk);
        chk("ramp_restart", 32'(assist_req), 64);
        chk("integ_restart", 32'(dut.u_core.integ), 30);

        // Continue: integ saturates at 1024, target 1500+2048=3548 at tick 56
        nt = 1;
        do begin
            tick_wait(1);
            nt++;
        end while (assist_req != 13'd3548 && nt < 80);
        chk("ramp_ticks", 32'(nt), 56);
        chk("ramp_final", 32'(assist_req), 3548);
        chk("integ_sat",  32'(dut.u_core.integ), 1024);
        tick_wait(1); chk("ramp_hold", 32'(assist_req), 3548);

        // Brake cut-off and re-ramp
        brake = 1'b1;
        @(negedge clk);
        chk("brake_req",   32'(assist_req), 0);
        chk("brake_state", 32'(state), 2);
        brake = 1'b0;
        @(negedge clk);
        chk("rel_state", 32'(state), 1);
        tick_wait(1); chk("rel_ramp1", 32'(assist_req), 64);
        tick_wait(1); chk("rel_ramp2", 32'(assist_req), 128);

        // Coast down to IDLE
        cadence = 1'b0;
        @(negedge clk);
        chk("coast_state", 32'(state), 2);
        tick_wait(1); chk("coast_req", 32'(assist_req), 64);
        tick_wait(1); chk("coast_zero", 32'(assist_req), 0);
        @(negedge clk);
        chk("coast_idle",  32'(state), 0);
        chk("idle_integ",  32'(dut.u_core.integ), 0);

        // Tilt kill: pitch=30 alone gives target 1500 (tick 24)
        heart_rate = 8'd120; pitch = 10'sd30; cadence = 1'b1;
        nt = 0;
        do begin
            tick_wait(1);
            nt++;
        end while (assist_req != 13'd1500 && nt < 40);
        chk("pitch_ticks", 32'(nt), 24);
        chk("pitch_req",   32'(assist_req), 1500);
        roll = 10'sd50;
        @(negedge clk);
        chk("tilt_req",   32'(assist_req), 0);
        chk("tilt_flag",  32'(tilt_fault), 1);
        chk("tilt_state", 32'(state), 3);
        roll = 10'sd20; cadence = 1'b0;
        tick_wait(9);
        roll = 10'sd40;
        tick_wait(1);
        chk("rec_viol", 32'(state), 3);
        roll = 10'sd20;
        tick_wait(15);
        chk("rec_15_state", 32'(state), 3);
        chk("rec_15_flag",  32'(tilt_fault), 1);
        tick_wait(1);
        chk("rec_state", 32'(state), 0);
        chk("rec_flag",  32'(tilt_fault), 0);

        // Anti-windup: err=140 -> integ frozen at 700, req saturates
        roll = '0; pitch = '0; heart_rate = 8'd200; hr_setpoint = 8'd60; cadence = 1'b1;
        tick_wait(140);
        chk("aw_req",   32'(assist_req), 8191);
        chk("aw_integ", 32'(dut.u_core.integ), 700);
        heart_rate = 8'd60;
        tick_wait(1);
        chk("aw_drop",       32'(assist_req), 1400);
        chk("aw_drop_integ", 32'(dut.u_core.integ), 700);

        // Negative error and downhill pitch: target clamps to 0
        cadence = 1'b0; brake = 1'b1;
        repeat (2) @(negedge clk);
        chk("neg_idle", 32'(state), 0);
        brake = 1'b0; cadence = 1'b1;
        heart_rate = 8'd100; hr_setpoint = 8'd120; pitch = -10'sd30;
        tick_wait(1); chk("neg_req1", 32'(assist_req), 0);
        tick_wait(2); chk("neg_req3", 32'(assist_req), 0);
        chk("neg_state", 32'(state), 1);
        chk("neg_integ", 32'($signed(dut.u_core.integ)), 32'(-20));

        // Simultaneous tilt (most-negative roll) and brake -> FAULT
        pitch = '0; heart_rate = 8'd150;
        tick_wait(1);
        brake = 1'b1; roll = -10'sd512;
        @(negedge clk);
        chk("tb_state", 32'(state), 3);
        chk("tb_flag",  32'(tilt_fault), 1);
        chk("tb_req",   32'(assist_req), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
